reorder_buffer: RTL and testbench

In-order reorder buffer that sits between rename and commit and closes the physical-register loop opened by the rename stage. It accepts renamed instructions (architectural rd, old and new physical rd), tracks completion out of order by ROB tag, and retires at most one instruction per cycle from the head. On each retirement it drives `prd_free`/`commit_free` back to rename so the superseded physical register returns to the free pool.

---
 rtl/rob_pkg.sv | 19 +
 rtl/reorder_buffer_if.sv | 31 +++
 rtl/rob_ptr.sv | 21 ++
 rtl/reorder_buffer.sv | 88 ++++++++
 tb/tb_reorder_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer slice.
package rob_pkg;

  localparam int unsigned NUM_REG   = 32;
  localparam int unsigned REG_SIZE  = $clog2(NUM_REG);
  localparam int unsigned PREG_W    = REG_SIZE + 1;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);
  localparam int unsigned PTR_W     = TAG_W + 1;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic [REG_SIZE-1:0] rd;
    logic [PREG_W-1:0]   prd_old;
    logic [PREG_W-1:0]   prd_new;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/execute <-> reorder buffer handshake bundle.
interface reorder_buffer_if
  import rob_pkg::*;
();
  logic                dispatch_valid;
  logic                dispatch_ready;
  logic [REG_SIZE-1:0] rd_A;
  logic [PREG_W-1:0]   prd_A_old;
  logic [PREG_W-1:0]   prd_A_new;
  logic [TAG_W-1:0]    rob_tag;
  logic                complete_valid;
  logic [TAG_W-1:0]    complete_tag;
  logic                commit_free;
  logic [PREG_W-1:0]   prd_free;
  logic                commit_valid;
  logic [REG_SIZE-1:0] commit_rd;
  logic [PREG_W-1:0]   commit_prd;
  logic                rob_empty;

  modport master (
    output dispatch_valid, rd_A, prd_A_old, prd_A_new, complete_valid, complete_tag,
    input  dispatch_ready, rob_tag, commit_free, prd_free, commit_valid, commit_rd,
           commit_prd, rob_empty
  );

  modport slave (
    input  dispatch_valid, rd_A, prd_A_old, prd_A_new, complete_valid, complete_tag,
    output dispatch_ready, rob_tag, commit_free, prd_free, commit_valid, commit_rd,
           commit_prd, rob_empty
  );
endinterface

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer; the extra MSB separates full from empty.
module rob_ptr
  import rob_pkg::*;
#(
  parameter int unsigned Width = PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + Width'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: out-of-order completion, single in-order retire per cycle.
// Optional ROB_COMPLETE_BYPASS_EN lets a completion to the head retire in the same cycle.
module reorder_buffer
  import rob_pkg::*;
(
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  logic             empty;
  logic             dispatch_fire;
  logic             bypass_hit;
  logic             commit_en;
  rob_entry_t       head_entry;
  rob_entry_t       mem [ROB_DEPTH];

  assign head_idx   = head[TAG_W-1:0];
  assign tail_idx   = tail[TAG_W-1:0];
  assign full       = (head[PTR_W-1] != tail[PTR_W-1]) && (head_idx == tail_idx);
  assign empty      = (head == tail);
  assign head_entry = mem[head_idx];

  // Space freed by a same-cycle commit is not offered to dispatch.
  assign dispatch_fire = bus.dispatch_valid && !full;

`ifdef ROB_COMPLETE_BYPASS_EN
  assign bypass_hit = bus.complete_valid && (bus.complete_tag == head_idx) &&
                      head_entry.valid && !head_entry.done;
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_en = head_entry.valid && (head_entry.done || bypass_hit);

  rob_ptr #(.Width(PTR_W)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .inc (commit_en),
    .ptr (head)
  );

  rob_ptr #(.Width(PTR_W)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .inc (dispatch_fire),
    .ptr (tail)
  );

  // Later writes win: a retiring head is cleared even if completed again this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.complete_valid && mem[bus.complete_tag].valid) begin
        mem[bus.complete_tag].done <= 1'b1;
      end
      if (dispatch_fire) begin
        mem[tail_idx] <= '{valid:   1'b1,
                           done:    1'b0,
                           rd:      bus.rd_A,
                           prd_old: bus.prd_A_old,
                           prd_new: bus.prd_A_new};
      end
      if (commit_en) begin
        mem[head_idx] <= '0;
      end
    end
  end

  assign bus.dispatch_ready = !full;
  assign bus.rob_tag        = tail_idx;
  assign bus.rob_empty      = empty;
  assign bus.commit_valid   = commit_en;
  assign bus.commit_rd      = commit_en ? head_entry.rd : '0;
  assign bus.commit_prd     = commit_en ? head_entry.prd_new : '0;
  assign bus.prd_free       = commit_en ? head_entry.prd_old : '0;
  // x0 writers retire but never return p0 to the free pool.
  assign bus.commit_free    = commit_en && (head_entry.rd != '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (bypass or non-bypass build).
module tb_reorder_buffer;
  import rob_pkg::*;

`ifdef ROB_COMPLETE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Queue model used by the wrap/random scenario.
  logic [4:0] mh, mt;
  logic       mv   [16];
  logic       md   [16];
  logic [4:0] mrd  [16];
  logic [5:0] mold [16];
  logic [5:0] mnew [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid = 1'b0;
    bus.rd_A           = '0;
    bus.prd_A_old      = '0;
    bus.prd_A_new      = '0;
    bus.complete_valid = 1'b0;
    bus.complete_tag   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    mh = '0;
    mt = '0;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  task automatic dispatch1(input logic [4:0] rd, input logic [5:0] old, input logic [5:0] nw);
    bus.dispatch_valid = 1'b1;
    bus.rd_A           = rd;
    bus.prd_A_old      = old;
    bus.prd_A_new      = nw;
    tick();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic mcycle(input logic dv, input logic [4:0] rd, input logic [5:0] old,
                        input logic [5:0] nw, input logic cv, input logic [3:0] ctag);
    logic       er, ecv;
    logic [3:0] hi, ti;
    bus.dispatch_valid = dv;
    bus.rd_A           = rd;
    bus.prd_A_old      = old;
    bus.prd_A_new      = nw;
    bus.complete_valid = cv;
    bus.complete_tag   = ctag;
    #1;
    hi  = mh[3:0];
    ti  = mt[3:0];
    er  = !((mh[4] != mt[4]) && (hi == ti));
    ecv = mv[hi] && (md[hi] || (Byp && cv && (ctag == hi)));
    tests += 5;
    if (bus.dispatch_ready !== er) begin
      fails++; $display("FAIL model_ready got=%0b exp=%0b", bus.dispatch_ready, er);
    end
    if (bus.rob_tag !== ti) begin
      fails++; $display("FAIL model_tag got=%0d exp=%0d", bus.rob_tag, ti);
    end
    if (bus.commit_valid !== ecv) begin
      fails++; $display("FAIL model_commit_valid got=%0b exp=%0b", bus.commit_valid, ecv);
    end
    if (bus.commit_rd !== (ecv ? mrd[hi] : 5'd0)) begin
      fails++; $display("FAIL model_commit_rd got=%0d exp=%0d", bus.commit_rd,
                        ecv ? mrd[hi] : 5'd0);
    end
    if (bus.prd_free !== (ecv ? mold[hi] : 6'd0)) begin
      fails++; $display("FAIL model_prd_free got=%0d exp=%0d", bus.prd_free,
                        ecv ? mold[hi] : 6'd0);
    end
    @(posedge clk);
    if (cv && mv[ctag]) md[ctag] = 1'b1;
    if (dv && er) begin
      mv[ti] = 1'b1; md[ti] = 1'b0; mrd[ti] = rd; mold[ti] = old; mnew[ti] = nw;
      mt = mt + 5'd1;
    end
    if (ecv) begin
      mv[hi] = 1'b0; md[hi] = 1'b0;
      mh = mh + 5'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests += 8;
    if (bus.dispatch_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%0b exp=1", bus.dispatch_ready); end
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL rst_empty got=%0b exp=1", bus.rob_empty); end
    if (bus.rob_tag !== 4'd0) begin fails++; $display("FAIL rst_tag got=%0d exp=0", bus.rob_tag); end
    if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL rst_cvalid got=%0b exp=0", bus.commit_valid); end
    if (bus.commit_free !== 1'b0) begin fails++; $display("FAIL rst_cfree got=%0b exp=0", bus.commit_free); end
    if (bus.prd_free !== 6'd0) begin fails++; $display("FAIL rst_prd_free got=%0d exp=0", bus.prd_free); end
    if (bus.commit_rd !== 5'd0) begin fails++; $display("FAIL rst_crd got=%0d exp=0", bus.commit_rd); end
    if (bus.commit_prd !== 6'd0) begin fails++; $display("FAIL rst_cprd got=%0d exp=0", bus.commit_prd); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) dispatch1(5'(k + 1), 6'(k + 1), 6'(k + 33));
    bus.complete_valid = 1'b1;
    bus.complete_tag   = 4'd1;
    tick();
    bus.complete_tag   = 4'd0;
    #1;
    tests += 3;
    if (bus.rob_empty !== 1'b0) begin fails++; $display("FAIL mid_live_empty got=%0b exp=0", bus.rob_empty); end
    if (bus.rob_tag !== 4'd5) begin fails++; $display("FAIL mid_live_tag got=%0d exp=5", bus.rob_tag); end
    if (bus.commit_valid !== Byp) begin fails++; $display("FAIL mid_live_cvalid got=%0b exp=%0b", bus.commit_valid, Byp); end
    rst = 1'b0;
    #1;
    tests += 6;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL mid_rst_empty got=%0b exp=1", bus.rob_empty); end
    if (bus.dispatch_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready got=%0b exp=1", bus.dispatch_ready); end
    if (bus.rob_tag !== 4'd0) begin fails++; $display("FAIL mid_rst_tag got=%0d exp=0", bus.rob_tag); end
    if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_cvalid got=%0b exp=0", bus.commit_valid); end
    if (bus.commit_free !== 1'b0) begin fails++; $display("FAIL mid_rst_cfree got=%0b exp=0", bus.commit_free); end
    if (bus.prd_free !== 6'd0) begin fails++; $display("FAIL mid_rst_prd_free got=%0d exp=0", bus.prd_free); end
    rst = 1'b1;
    tick();
    bus.complete_valid = 1'b0;
    #1;
    tests += 2;
    if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL mid_after_cvalid got=%0b exp=0", bus.commit_valid); end
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL mid_after_empty got=%0b exp=1", bus.rob_empty); end
  endtask

  task automatic test_basic_retire();
    do_reset();
    bus.dispatch_valid = 1'b1;
    bus.rd_A = 5'd5; bus.prd_A_old = 6'd5; bus.prd_A_new = 6'd40;
    #1;
    tests++;
    if (bus.rob_tag !== 4'd0) begin fails++; $display("FAIL basic_tag got=%0d exp=0", bus.rob_tag); end
    tick();
    bus.dispatch_valid = 1'b0;
    bus.complete_valid = 1'b1;
    bus.complete_tag   = 4'd0;
    #1;
    tests += 2;
    if (bus.commit_free !== Byp) begin fails++; $display("FAIL basic_c0_cfree got=%0b exp=%0b", bus.commit_free, Byp); end
    if (bus.prd_free !== (Byp ? 6'd5 : 6'd0)) begin fails++; $display("FAIL basic_c0_prd_free got=%0d", bus.prd_free); end
    tick();
    bus.complete_valid = 1'b0;
    #1;
    tests += 5;
    if (bus.commit_free !== !Byp) begin fails++; $display("FAIL basic_c1_cfree got=%0b exp=%0b", bus.commit_free, !Byp); end
    if (bus.prd_free !== (Byp ? 6'd0 : 6'd5)) begin fails++; $display("FAIL basic_c1_prd_free got=%0d", bus.prd_free); end
    if (bus.commit_prd !== (Byp ? 6'd0 : 6'd40)) begin fails++; $display("FAIL basic_c1_cprd got=%0d", bus.commit_prd); end
    if (bus.commit_rd !== (Byp ? 5'd0 : 5'd5)) begin fails++; $display("FAIL basic_c1_crd got=%0d", bus.commit_rd); end
    if (bus.rob_empty !== Byp) begin fails++; $display("FAIL basic_c1_empty got=%0b exp=%0b", bus.rob_empty, Byp); end
    tick();
    tests++;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL basic_end_empty got=%0b exp=1", bus.rob_empty); end
  endtask

  task automatic test_out_of_order();
    int start;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      bus.dispatch_valid = 1'b1;
      bus.rd_A = 5'(k); bus.prd_A_old = 6'(9 + k); bus.prd_A_new = 6'(32 + k);
      #1;
      tests++;
      if (bus.rob_tag !== 4'(k - 1)) begin fails++; $display("FAIL ooo_tag got=%0d exp=%0d", bus.rob_tag, k - 1); end
      tick();
    end
    bus.dispatch_valid = 1'b0;
    bus.complete_valid = 1'b1;
    for (int t = 2; t >= 1; t--) begin
      bus.complete_tag = 4'(t);
      #1;
      tests++;
      if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL ooo_early_commit got=%0b exp=0", bus.commit_valid); end
      tick();
    end
    bus.complete_tag = 4'd0;
    #1;
    tests++;
    if (bus.commit_rd !== (Byp ? 5'd1 : 5'd0)) begin fails++; $display("FAIL ooo_c0_crd got=%0d", bus.commit_rd); end
    tick();
    bus.complete_valid = 1'b0;
    #1;
    start = Byp ? 2 : 1;
    for (int k = start; k <= 3; k++) begin
      tests += 3;
      if (bus.commit_valid !== 1'b1) begin fails++; $display("FAIL ooo_cvalid got=%0b exp=1", bus.commit_valid); end
      if (bus.commit_rd !== 5'(k)) begin fails++; $display("FAIL ooo_order got=%0d exp=%0d", bus.commit_rd, k); end
      if (bus.prd_free !== 6'(9 + k)) begin fails++; $display("FAIL ooo_prd_free got=%0d exp=%0d", bus.prd_free, 9 + k); end
      tick();
    end
    tests += 2;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL ooo_empty got=%0b exp=1", bus.rob_empty); end
    if (bus.commit_valid !== 1'b0) begin fails++; $display("FAIL ooo_idle got=%0b exp=0", bus.commit_valid); end
  endtask

  task automatic test_x0_writer();
    do_reset();
    dispatch1(5'd0, 6'd0, 6'd0);
    bus.complete_valid = 1'b1;
    bus.complete_tag   = 4'd0;
    #1;
    tests += 2;
    if (bus.commit_valid !== Byp) begin fails++; $display("FAIL x0_c0_cvalid got=%0b exp=%0b", bus.commit_valid, Byp); end
    if (bus.commit_free !== 1'b0) begin fails++; $display("FAIL x0_c0_cfree got=%0b exp=0", bus.commit_free); end
    tick();
    bus.complete_valid = 1'b0;
    #1;
    tests += 2;
    if (bus.commit_valid !== !Byp) begin fails++; $display("FAIL x0_c1_cvalid got=%0b exp=%0b", bus.commit_valid, !Byp); end
    if (bus.commit_free !== 1'b0) begin fails++; $display("FAIL x0_c1_cfree got=%0b exp=0", bus.commit_free); end
    tick();
    tests++;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL x0_empty got=%0b exp=1", bus.rob_empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) mcycle(1'b1, 5'(i + 1), 6'(i), 6'(32 + i), 1'b0, 4'd0);
    tests += 2;
    if (bus.dispatch_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%0b exp=0", bus.dispatch_ready); end
    if (bus.rob_empty !== 1'b0) begin fails++; $display("FAIL full_empty got=%0b exp=0", bus.rob_empty); end
    mcycle(1'b1, 5'd31, 6'd31, 6'd63, 1'b0, 4'd0);
    mcycle(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 4'd0);
    tests++;
    if (bus.rob_tag !== 4'd0) begin fails++; $display("FAIL wrap_tag got=%0d exp=0", bus.rob_tag); end
    mcycle(1'b1, 5'd20, 6'd20, 6'd20, 1'b0, 4'd0);
    mcycle(1'b1, 5'd21, 6'd21, 6'd21, 1'b0, 4'd0);
    for (int n = 0; n < 40; n++) begin
      mcycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
             6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
             4'(mh[3:0] + 4'($urandom_range(0, 15))));
    end
    for (int k = 0; k < 40 && mh != mt; k++) begin
      mcycle(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, mh[3:0]);
    end
    idle();
    tick();
    tests++;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL drain_empty got=%0b exp=1", bus.rob_empty); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int k = 1; k <= 3; k++) dispatch1(5'(k), 6'(k), 6'(k + 40));
    bus.complete_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bus.complete_tag = 4'(t);
      tick();
    end
    bus.complete_valid = 1'b0;
    tick();
    tick();
    tests += 2;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL byp_pre_empty got=%0b exp=1", bus.rob_empty); end
    if (bus.rob_tag !== 4'd3) begin fails++; $display("FAIL byp_pre_tag got=%0d exp=3", bus.rob_tag); end
    dispatch1(5'd7, 6'd7, 6'd50);
    bus.complete_valid = 1'b1;
    bus.complete_tag   = 4'd3;
    #1;
    tests += 2;
    if (bus.commit_free !== Byp) begin fails++; $display("FAIL byp_same_cfree got=%0b exp=%0b", bus.commit_free, Byp); end
    if (bus.prd_free !== (Byp ? 6'd7 : 6'd0)) begin fails++; $display("FAIL byp_same_prd_free got=%0d", bus.prd_free); end
    tick();
    bus.complete_valid = 1'b0;
    #1;
    tests += 2;
    if (bus.commit_free !== !Byp) begin fails++; $display("FAIL byp_next_cfree got=%0b exp=%0b", bus.commit_free, !Byp); end
    if (bus.prd_free !== (Byp ? 6'd0 : 6'd7)) begin fails++; $display("FAIL byp_next_prd_free got=%0d", bus.prd_free); end
    tick();
    tests++;
    if (bus.rob_empty !== 1'b1) begin fails++; $display("FAIL byp_end_empty got=%0b exp=1", bus.rob_empty); end
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b0;
    tests = 0;
    fails = 0;
    mh    = '0;
    mt    = '0;
    idle();
    test_reset();
    test_basic_retire();
    test_out_of_order();
    test_x0_writer();
    test_full_wrap();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
